// File: rtl/sub_f64_share_arbiter.sv
// sub_f64_share_arbiter
//   Shares one ap_ctrl_hs subFloat64Sigs unit among NUM_REQ requesters.
//   A round-robin pick selects one pending lane. The arbiter captures that
//   lane's operands, runs the unit's start/ready/done handshake, and returns
//   the result to the owning lane.
//
// Ports
//   ap_clk, ap_rst        clock; synchronous active-high reset (shared with unit)
//   req_valid[i]          lane i request level, held until req_grant[i]
//   req_a / req_b         packed operands, lane i at [i*DATA_W +: DATA_W]
//   req_zsign[i]          result sign for lane i
//   req_grant             one-hot, 1-cycle pulse: operands of that lane captured
//   rsp_valid             one-hot, 1-cycle pulse: rsp_data belongs to that lane
//   rsp_data              shared result bus, holds until the next capture
//   unit_ap_start/ready/done/return   handshake with the shared unit
//   unit_a/unit_b/unit_zsign          captured operands presented to the unit
//   busy                  high whenever the FSM is not IDLE
//   op_count              completed operations, wraps modulo 2^CNT_W
//   state_dbg             current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Handshake semantics
//   Request side: a lane raises req_valid and keeps it high until it sees its
//   req_grant pulse. The grant marks the cycle its operands were captured.
//   After the grant, req_valid is a don't-care until the lane's rsp_valid pulse.
//   Unit side: unit_ap_start stays high until unit_ap_ready is sampled high.
//   The result is taken on the first unit_ap_done seen in ISSUE or WAIT.
//   unit_ap_done in any other state is ignored.

module sub_f64_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_zsign,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      unit_ap_start,
    input  logic                      unit_ap_ready,
    input  logic                      unit_ap_done,
    input  logic [DATA_W-1:0]         unit_ap_return,
    output logic [DATA_W-1:0]         unit_a,
    output logic [DATA_W-1:0]         unit_b,
    output logic                      unit_zsign,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count,
    output logic [1:0]                state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic             found;

    // Round-robin scan: first requesting lane at or after ptr, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            req_grant     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            unit_ap_start <= 1'b0;
            unit_a        <= '0;
            unit_b        <= '0;
            unit_zsign    <= 1'b0;
            op_count      <= '0;
        end else begin
            // Grant and response are single-cycle pulses by default.
            req_grant <= '0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner         <= winner;
                        unit_a        <= req_a[int'(winner)*DATA_W +: DATA_W];
                        unit_b        <= req_b[int'(winner)*DATA_W +: DATA_W];
                        unit_zsign    <= req_zsign[winner];
                        req_grant     <= NUM_REQ'(1) << winner;
                        unit_ap_start <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (unit_ap_ready) begin
                        unit_ap_start <= 1'b0;
                        if (unit_ap_done) begin
                            // Unit finished in the accept cycle: skip WAIT.
                            rsp_data  <= unit_ap_return;
                            rsp_valid <= NUM_REQ'(1) << owner;
                            state     <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (unit_ap_done) begin
                        rsp_data  <= unit_ap_return;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // rsp_valid is high during this cycle. Close out the op
                    // and hand priority to the lane after the owner.
                    op_count <= op_count + CNT_W'(1);
                    if (int'(owner) == NUM_REQ - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= owner + PTR_W'(1);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule
